// File: rtl/mmu_pkg.sv
// Shared constants for the KT-11 MMU I/O-page responder: register base addresses,
// pxr_addr field encodings and the bus-slave FSM encoding.
package mmu_pkg;

   localparam int unsigned PaW = 22;

   localparam logic [PaW-1:0] KernBase  = 22'o17772300;
   localparam logic [PaW-1:0] SuperBase = 22'o17772200;
   localparam logic [PaW-1:0] UserBase  = 22'o17777600;
   localparam logic [PaW-1:0] Mmr0Addr  = 22'o17777572;
   localparam logic [PaW-1:0] Mmr1Addr  = 22'o17777574;
   localparam logic [PaW-1:0] Mmr2Addr  = 22'o17777576;
   localparam logic [PaW-1:0] Mmr3Addr  = 22'o17772516;

   localparam logic [1:0] Mmr0Idx = 2'd0;
   localparam logic [1:0] Mmr1Idx = 2'd1;
   localparam logic [1:0] Mmr2Idx = 2'd2;
   localparam logic [1:0] Mmr3Idx = 2'd3;

   typedef enum logic [1:0] {
      ModeKernel = 2'b00,
      ModeSuper  = 2'b01,
      ModeUser   = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StRmwRd,
      StWr,
      StAck
   } state_e;

   // pxr_addr layout: {mmr, par, mode[1:0], D, apf[2:0]}
   function automatic logic [7:0] pxr_page_addr(logic par, mode_e mode, logic d,
                                                logic [2:0] apf);
      return {1'b0, par, mode, d, apf};
   endfunction

   function automatic logic [7:0] pxr_mmr_addr(logic [1:0] idx);
      return {1'b1, 5'b00000, idx};
   endfunction

endpackage

// File: rtl/mmu_bus_slave_if.sv
// Bus-side and pxr-port signals of the MMU I/O-page responder.
interface mmu_bus_slave_if #(
   parameter int unsigned ADDR_W = 22
);
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_rd;
   logic              bus_wr;
   logic              bus_byte;
   logic [15:0]       bus_data_in;
   logic [15:0]       bus_data_out;
   logic              bus_ack;
   logic              bus_hit;
   logic              pxr_rd;
   logic              pxr_wr;
   logic [7:0]        pxr_addr;
   logic [15:0]       pxr_data_out;
   logic [15:0]       pxr_data_in;

   modport slave (
      input  bus_addr, bus_rd, bus_wr, bus_byte, bus_data_in, pxr_data_in,
      output bus_data_out, bus_ack, bus_hit, pxr_rd, pxr_wr, pxr_addr, pxr_data_out
   );

   modport master (
      output bus_addr, bus_rd, bus_wr, bus_byte, bus_data_in, pxr_data_in,
      input  bus_data_out, bus_ack, bus_hit, pxr_rd, pxr_wr, pxr_addr, pxr_data_out
   );

endinterface

// File: rtl/mmu_addr_decode.sv
// Combinational I/O-page decoder: word address -> {hit, pxr_addr, read_only}.
module mmu_addr_decode
   import mmu_pkg::*;
#(
   parameter int unsigned ADDR_W       = 22,
   parameter bit          ENABLE_SUPER = 1'b1,
   parameter bit          ENABLE_MMR3  = 1'b1
) (
   input  logic [ADDR_W-1:1] i_word_addr,
   output logic              o_hit,
   output logic [7:0]        o_pxr_addr,
   output logic              o_ro
);

   logic [PaW-1:1] w_pa;
   assign w_pa = (PaW-1)'(i_word_addr);

   always_comb begin
      o_hit      = 1'b0;
      o_pxr_addr = 8'h00;
      o_ro       = 1'b0;
      if (w_pa[PaW-1:6] == KernBase[PaW-1:6]) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_page_addr(w_pa[5], ModeKernel, w_pa[4], w_pa[3:1]);
      end else if (ENABLE_SUPER && (w_pa[PaW-1:6] == SuperBase[PaW-1:6])) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_page_addr(w_pa[5], ModeSuper, w_pa[4], w_pa[3:1]);
      end else if (w_pa[PaW-1:6] == UserBase[PaW-1:6]) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_page_addr(w_pa[5], ModeUser, w_pa[4], w_pa[3:1]);
      end else if (w_pa == Mmr0Addr[PaW-1:1]) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_mmr_addr(Mmr0Idx);
      end else if (w_pa == Mmr1Addr[PaW-1:1]) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_mmr_addr(Mmr1Idx);
         o_ro       = 1'b1;
      end else if (w_pa == Mmr2Addr[PaW-1:1]) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_mmr_addr(Mmr2Idx);
         o_ro       = 1'b1;
      end else if (ENABLE_MMR3 && (w_pa == Mmr3Addr[PaW-1:1])) begin
         o_hit      = 1'b1;
         o_pxr_addr = pxr_mmr_addr(Mmr3Idx);
      end
   end

endmodule

// File: rtl/mmu_bus_slave.sv
// I/O-page bus responder for the MMU register file; drives the pxr register port
// and performs read-modify-write for byte writes.
module mmu_bus_slave
   import mmu_pkg::*;
#(
   parameter int unsigned ADDR_W       = 22,
   parameter bit          ENABLE_SUPER = 1'b1,
   parameter bit          ENABLE_MMR3  = 1'b1
) (
   input logic            clk,
   input logic            reset_n,
   mmu_bus_slave_if.slave bus
);

   logic        w_hit;
   logic        w_ro;
   logic [7:0]  w_pxr_addr;
   logic        w_req;
   state_e      r_state;
   state_e      w_state_next;
   logic [7:0]  r_pxr_addr;
   logic [15:0] r_wdata;
   logic [15:0] r_rdata;
   logic        r_lane;
   logic        r_ro;

   mmu_addr_decode #(
      .ADDR_W       (ADDR_W),
      .ENABLE_SUPER (ENABLE_SUPER),
      .ENABLE_MMR3  (ENABLE_MMR3)
   ) u_decode (
      .i_word_addr (bus.bus_addr[ADDR_W-1:1]),
      .o_hit       (w_hit),
      .o_pxr_addr  (w_pxr_addr),
      .o_ro        (w_ro)
   );

   assign w_req = (bus.bus_rd | bus.bus_wr) & w_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= StIdle;
      else          r_state <= w_state_next;
   end

   // Write wins when both strobes are set.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (w_req) begin
               if (!bus.bus_wr)       w_state_next = StRd;
               else if (bus.bus_byte) w_state_next = StRmwRd;
               else                   w_state_next = StWr;
            end
         end
         StRd:    w_state_next = StAck;
         StRmwRd: w_state_next = StWr;
         StWr:    w_state_next = StAck;
         StAck:   if (!bus.bus_rd && !bus.bus_wr) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pxr_addr <= 8'h00;
         r_wdata    <= 16'h0000;
         r_rdata    <= 16'h0000;
         r_lane     <= 1'b0;
         r_ro       <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (w_req) begin
                  r_pxr_addr <= w_pxr_addr;
                  r_wdata    <= bus.bus_data_in;
                  r_lane     <= bus.bus_addr[0];
                  r_ro       <= w_ro;
                  r_rdata    <= 16'h0000;
               end
            end
            StRd:    r_rdata <= bus.pxr_data_in;
            StRmwRd: r_wdata <= r_lane ? {r_wdata[15:8], bus.pxr_data_in[7:0]}
                                       : {bus.pxr_data_in[15:8], r_wdata[7:0]};
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.bus_hit      = w_hit;
      bus.pxr_rd       = (r_state == StRd) || (r_state == StRmwRd);
      bus.pxr_wr       = (r_state == StWr) && !r_ro;
      bus.pxr_addr     = r_pxr_addr;
      bus.pxr_data_out = r_wdata;
      bus.bus_ack      = (r_state == StAck);
      bus.bus_data_out = (r_state == StAck) ? r_rdata : 16'h0000;
   end

endmodule

// File: tb/tb_mmu_bus_slave.sv
// Self-checking bench for mmu_bus_slave: directed vector table, randomized traffic
// against an address-map reference model, reset-in-flight and disabled-range checks.
module tb_mmu_bus_slave;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_fail;

   mmu_bus_slave_if #(.ADDR_W(22)) if0 ();
   mmu_bus_slave_if #(.ADDR_W(22)) if1 ();

   mmu_bus_slave #(.ADDR_W(22), .ENABLE_SUPER(1'b1), .ENABLE_MMR3(1'b1)) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if0)
   );

   mmu_bus_slave #(.ADDR_W(22), .ENABLE_SUPER(1'b0), .ENABLE_MMR3(1'b0)) u_dut_min (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (if1)
   );

   // MMU register file model and the bench's expected copy of it.
   logic [15:0] mmu_mem [256];
   logic [15:0] exp_mem [256];
   int          rd_cnt, wr_cnt, both_err;
   logic [7:0]  last_pxa;
   logic [15:0] last_wdata;

   assign if0.pxr_data_in = if0.pxr_rd ? mmu_mem[if0.pxr_addr] : 16'h0000;
   assign if1.pxr_data_in = 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rd, wr, byt;
      logic [21:0] addr;
      logic [15:0] data;
      logic [15:0] preload;
      bit          hit;
      logic [7:0]  pxa;
      int          edges, rdn, wrn;
      logic [15:0] rdata;
      logic [15:0] mem_after;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Observe pxr strobes at the negedge (the mmu commits writes at the next edge).
   task automatic step();
      @(negedge clk);
      if (if0.pxr_rd && if0.pxr_wr) both_err++;
      if (if0.pxr_rd) begin
         rd_cnt++;
         last_pxa = if0.pxr_addr;
      end
      if (if0.pxr_wr) begin
         wr_cnt++;
         last_pxa   = if0.pxr_addr;
         last_wdata = if0.pxr_data_out;
         mmu_mem[if0.pxr_addr] = if0.pxr_data_out;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic void ref_decode(input logic [21:0] a, output bit hit,
                                      output logic [7:0] pxa, output bit ro);
      int ai, off, mode, mmr;
      bit page;
      ai = int'(a); page = 0; hit = 0; ro = 0; pxa = 8'h00; mmr = -1; off = 0; mode = 0;
      if (ai >= 'o17772300 && ai <= 'o17772377) begin page = 1; mode = 0; off = ai - 'o17772300; end
      else if (ai >= 'o17772200 && ai <= 'o17772277) begin page = 1; mode = 1; off = ai - 'o17772200; end
      else if (ai >= 'o17777600 && ai <= 'o17777677) begin page = 1; mode = 3; off = ai - 'o17777600; end
      else if (ai / 2 == 'o17777572 / 2) mmr = 0;
      else if (ai / 2 == 'o17777574 / 2) mmr = 1;
      else if (ai / 2 == 'o17777576 / 2) mmr = 2;
      else if (ai / 2 == 'o17772516 / 2) mmr = 3;
      if (page) begin
         hit = 1;
         pxa = 8'((off >= 32 ? 64 : 0) + mode * 16 + ((off % 32) >= 16 ? 8 : 0) + (off % 16) / 2);
      end else if (mmr >= 0) begin
         hit = 1;
         pxa = 8'(128 + mmr);
         ro  = (mmr == 1 || mmr == 2);
      end
   endfunction

   task automatic check_xfer(input string tag, input bit rd, input bit wr, input bit byt,
                             input logic [21:0] addr, input logic [15:0] data, input bit e_hit,
                             input logic [7:0] e_pxa, input int e_edges, input int e_rdn,
                             input int e_wrn, input logic [15:0] e_rdata,
                             input logic [15:0] e_mem);
      int          rd0, wr0, edges;
      logic        hit, held, dropped;
      logic [15:0] rdata;
      rd0 = rd_cnt; wr0 = wr_cnt; edges = 0; rdata = 16'h0000; held = 1'b0;
      if0.bus_addr = addr; if0.bus_data_in = data; if0.bus_byte = byt;
      if0.bus_rd = rd; if0.bus_wr = wr;
      #1;
      hit = if0.bus_hit;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (if0.bus_ack) begin
            edges = i;
            break;
         end
      end
      if (edges != 0) begin
         rdata = if0.bus_data_out;
         step();
         held = if0.bus_ack;
      end
      if0.bus_rd = 1'b0; if0.bus_wr = 1'b0;
      step();
      dropped = if0.bus_ack;
      step();
      chk({tag, " hit"}, hit, e_hit);
      chk({tag, " ack_edges"}, edges, e_edges);
      chk({tag, " ack_held"}, held, e_hit);
      chk({tag, " ack_drop"}, dropped, 1'b0);
      chk({tag, " pxr_rd_cnt"}, rd_cnt - rd0, e_rdn);
      chk({tag, " pxr_wr_cnt"}, wr_cnt - wr0, e_wrn);
      chk({tag, " rdata"}, rdata, e_rdata);
      if (e_rdn + e_wrn > 0) chk({tag, " pxr_addr"}, last_pxa, e_pxa);
      if (e_wrn > 0) chk({tag, " pxr_wdata"}, last_wdata, e_mem);
      if (e_hit) begin
         chk({tag, " mem"}, mmu_mem[e_pxa], e_mem);
         exp_mem[e_pxa] = e_mem;
      end
   endtask

   task automatic ref_xfer(input string tag, input bit rd, input bit wr, input bit byt,
                           input logic [21:0] addr, input logic [15:0] data);
      bit          hit, ro;
      logic [7:0]  pxa;
      logic [15:0] old, nw, rdv;
      int          edges, rdn, wrn;
      ref_decode(addr, hit, pxa, ro);
      old   = exp_mem[pxa];
      nw    = old;
      if (hit && wr && !ro) begin
         if (!byt)        nw = data;
         else if (addr[0]) nw = (data & 16'hFF00) | (old & 16'h00FF);
         else             nw = (old & 16'hFF00) | (data & 16'h00FF);
      end
      edges = !hit ? 0 : (wr && byt) ? 3 : 2;
      rdn   = (hit && (!wr || byt)) ? 1 : 0;
      wrn   = (hit && wr && !ro) ? 1 : 0;
      rdv   = (hit && !wr) ? old : 16'h0000;
      check_xfer(tag, rd, wr, byt, addr, data, hit, pxa, edges, rdn, wrn, rdv, nw);
   endtask

   initial begin
      logic [15:0] v;
      logic [21:0] a;
      int          op;
      n_chk = 0; n_fail = 0; rd_cnt = 0; wr_cnt = 0; both_err = 0;
      last_pxa = 8'h00; last_wdata = 16'h0000;
      for (int i = 0; i < 256; i++) begin
         v = 16'($urandom);
         mmu_mem[i] = v;
         exp_mem[i] = v;
      end
      vecs[0]  = '{0, 1, 0, 22'o17772340, 16'o001234, 16'h0000, 1, 8'h40, 2, 0, 1, 16'h0000, 16'o001234};
      vecs[1]  = '{1, 0, 0, 22'o17777646, 16'h0000, 16'h5A5A, 1, 8'h73, 2, 1, 0, 16'h5A5A, 16'h5A5A};
      vecs[2]  = '{0, 1, 1, 22'o17772301, 16'h7F00, 16'h0006, 1, 8'h00, 3, 1, 1, 16'h0000, 16'h7F06};
      vecs[3]  = '{0, 1, 1, 22'o17772300, 16'h00FF, 16'h1234, 1, 8'h00, 3, 1, 1, 16'h0000, 16'h12FF};
      vecs[4]  = '{1, 0, 0, 22'o17777572, 16'h0000, 16'h0001, 1, 8'h80, 2, 1, 0, 16'h0001, 16'h0001};
      vecs[5]  = '{1, 0, 0, 22'o17772516, 16'h0000, 16'h0030, 1, 8'h83, 2, 1, 0, 16'h0030, 16'h0030};
      vecs[6]  = '{0, 1, 0, 22'o17777576, 16'h1111, 16'h2222, 1, 8'h82, 2, 0, 0, 16'h0000, 16'h2222};
      vecs[7]  = '{1, 0, 0, 22'o17772400, 16'h0000, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 16'h0000};
      vecs[8]  = '{0, 1, 0, 22'o17777700, 16'h4444, 16'h0000, 0, 8'h00, 0, 0, 0, 16'h0000, 16'h0000};
      vecs[9]  = '{1, 1, 0, 22'o17772300, 16'h4321, 16'h0000, 1, 8'h00, 2, 0, 1, 16'h0000, 16'h4321};
      vecs[10] = '{1, 0, 0, 22'o17772246, 16'h0000, 16'hABCD, 1, 8'h53, 2, 1, 0, 16'hABCD, 16'hABCD};
      vecs[11] = '{0, 1, 1, 22'o17777617, 16'hA500, 16'h00C3, 1, 8'h37, 3, 1, 1, 16'h0000, 16'hA5C3};

      reset_n = 1'b0;
      if0.bus_addr = '0; if0.bus_rd = 0; if0.bus_wr = 0; if0.bus_byte = 0; if0.bus_data_in = '0;
      if1.bus_addr = '0; if1.bus_rd = 0; if1.bus_wr = 0; if1.bus_byte = 0; if1.bus_data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ack", if0.bus_ack, 1'b0);
      chk("reset pxr_strobes", {if0.pxr_rd, if0.pxr_wr}, 2'b00);
      chk("reset pxr_addr", if0.pxr_addr, 8'h00);
      chk("reset outputs_data", {if0.pxr_data_out, if0.bus_data_out}, 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].hit) begin
            mmu_mem[vecs[i].pxa] = vecs[i].preload;
            exp_mem[vecs[i].pxa] = vecs[i].preload;
         end
         check_xfer($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].byt, vecs[i].addr,
                    vecs[i].data, vecs[i].hit, vecs[i].pxa, vecs[i].edges, vecs[i].rdn,
                    vecs[i].wrn, vecs[i].rdata, vecs[i].mem_after);
      end

      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 6))
            0:       a = 22'('o17772300 + $urandom_range(0, 63));
            1:       a = 22'('o17772200 + $urandom_range(0, 63));
            2:       a = 22'('o17777600 + $urandom_range(0, 63));
            3:       a = 22'('o17777572 + $urandom_range(0, 5));
            4:       a = 22'('o17772516 + $urandom_range(0, 1));
            5:       a = 22'($urandom);
            default: a = 22'('o17772200 + $urandom_range(0, 511));
         endcase
         op = $urandom_range(0, 3);
         ref_xfer($sformatf("rnd%0d", i), op == 0 || op == 3, op != 0, (op == 2) || (op == 3 && $urandom_range(0, 1) == 1),
                  a, 16'($urandom));
      end

      // Reset while the byte write sits in WR: the write must never reach the mmu.
      v = mmu_mem[8'h00];
      if0.bus_addr = 22'o17772301; if0.bus_data_in = 16'h5500; if0.bus_byte = 1;
      if0.bus_wr = 1;
      step();
      step();
      chk("rst pre_wr", if0.pxr_wr, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("rst ack", if0.bus_ack, 1'b0);
      chk("rst pxr_strobes", {if0.pxr_rd, if0.pxr_wr}, 2'b00);
      chk("rst pxr_addr", if0.pxr_addr, 8'h00);
      chk("rst outputs_data", {if0.pxr_data_out, if0.bus_data_out}, 32'h0);
      if0.bus_wr = 0; if0.bus_byte = 0;
      step();
      reset_n = 1'b1;
      step();
      chk("rst no_write", mmu_mem[8'h00], v);
      chk("rst idle_ack", if0.bus_ack, 1'b0);
      ref_xfer("post_rst", 0, 1, 0, 22'o17772340, 16'hBEEF);

      // Instance with supervisor range and MMR3 disabled.
      if1.bus_addr = 22'o17772516; if1.bus_rd = 1;
      #1;
      chk("min mmr3_hit", if1.bus_hit, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("min mmr3_noack", {if1.bus_ack, if1.pxr_rd, if1.pxr_wr}, 3'b000);
      if1.bus_addr = 22'o17772246;
      #1;
      chk("min super_hit", if1.bus_hit, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("min super_noack", {if1.bus_ack, if1.pxr_rd, if1.pxr_wr}, 3'b000);
      if1.bus_addr = 22'o17772300;
      repeat (3) @(posedge clk);
      #1;
      chk("min kern_ack", if1.bus_ack, 1'b1);
      if1.bus_rd = 0;

      chk("pxr rd_wr_exclusive", both_err, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
